// File: rtl/pls_acq_seq_if.sv
// Counter and FIFO side of the acquisition sequencer.
// The master is the sequencer; the slave is the counter/FIFO pair.
interface pls_acq_seq_if;
    // counter control and count stream
    logic        cnt_reset;
    logic        cnt_write;
    logic [31:0] cnt_tao;
    logic        cnt_trig;
    logic        cnt_rdy;
    logic [63:0] cnt_stream;
    // downstream FIFO write port
    logic [63:0] fifo_data;
    logic        fifo_wr;
    logic        fifo_full;

    modport master (
        output cnt_reset,
        output cnt_write,
        output cnt_tao,
        output cnt_trig,
        input  cnt_rdy,
        input  cnt_stream,
        output fifo_data,
        output fifo_wr,
        input  fifo_full
    );

    modport slave (
        input  cnt_reset,
        input  cnt_write,
        input  cnt_tao,
        input  cnt_trig,
        output cnt_rdy,
        output cnt_stream,
        input  fifo_data,
        input  fifo_wr,
        output fifo_full
    );
endinterface

// File: rtl/pls_acq_seq.sv
// Acquisition sequencer for the photon pulse counter: runs the counter
// through reset, configuration write and trigger, then captures each
// emitted 64-bit count word into the downstream FIFO. All outputs are
// registered.
module pls_acq_seq #(
    parameter int unsigned NF_W   = 16,
    parameter int unsigned TRIG_W = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [31:0]       cfg_tao,
    input  logic [NF_W-1:0]   cfg_nframes,
    input  logic [TRIG_W-1:0] cfg_trig_len,
    pls_acq_seq_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              overflow,
    output logic [NF_W-1:0]   frames_done
);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        LOAD,
        ARM,
        RUN,
        FIN
    } state_t;

    localparam logic [31:0] TAO_IDLE = 32'h0000_FFFF;

    state_t             state;
    logic [TRIG_W-1:0]  cyc_r;
    logic [31:0]        tao_r;
    logic [NF_W-1:0]    nf_r;
    logic [TRIG_W-1:0]  tl_r;

    logic               cnt_reset_r;
    logic               cnt_write_r;
    logic [31:0]        cnt_tao_r;
    logic               cnt_trig_r;
    logic [63:0]        fifo_data_r;
    logic               fifo_wr_r;

    logic [31:0]        tao_clamp;
    logic [TRIG_W-1:0]  tl_clamp;
    logic [NF_W-1:0]    frames_inc;
    logic               capture;
    logic               last_frame;

    assign bus.cnt_reset = cnt_reset_r;
    assign bus.cnt_write = cnt_write_r;
    assign bus.cnt_tao   = cnt_tao_r;
    assign bus.cnt_trig  = cnt_trig_r;
    assign bus.fifo_data = fifo_data_r;
    assign bus.fifo_wr   = fifo_wr_r;

    // Start-time clamps, frame accounting and completion detection
    always_comb begin
        tao_clamp  = (cfg_tao == '0) ? 32'd1 : cfg_tao;
        tl_clamp   = (cfg_trig_len == '0) ? TRIG_W'(1) : cfg_trig_len;
        frames_inc = frames_done + NF_W'(1);
        capture    = ((state == ARM) || (state == RUN)) && bus.cnt_rdy;
        last_frame = (nf_r != '0) && (frames_inc == nf_r);
    end

    // Sequencer state machine with registered outputs
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= IDLE;
            cyc_r       <= '0;
            tao_r       <= '0;
            nf_r        <= '0;
            tl_r        <= '0;
            cnt_reset_r <= 1'b1;
            cnt_write_r <= 1'b0;
            cnt_tao_r   <= TAO_IDLE;
            cnt_trig_r  <= 1'b0;
            fifo_data_r <= '0;
            fifo_wr_r   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            overflow    <= 1'b0;
            frames_done <= '0;
        end else begin
            fifo_wr_r <= 1'b0;
            done      <= 1'b0;

            if ((state != IDLE) && cfg_abort) begin
                // abort beats any frame captured this cycle: no count, no write
                state       <= IDLE;
                busy        <= 1'b0;
                aborted     <= 1'b1;
                cnt_reset_r <= 1'b0;
                cnt_write_r <= 1'b0;
                cnt_trig_r  <= 1'b0;
                cnt_tao_r   <= TAO_IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        cnt_reset_r <= 1'b0;
                        if (cfg_start) begin
                            state       <= CLR;
                            busy        <= 1'b1;
                            cnt_reset_r <= 1'b1;
                            tao_r       <= tao_clamp;
                            nf_r        <= cfg_nframes;
                            tl_r        <= tl_clamp;
                            cnt_tao_r   <= tao_clamp;
                            cyc_r       <= '0;
                            frames_done <= '0;
                            aborted     <= 1'b0;
                            overflow    <= 1'b0;
                        end
                    end
                    CLR: begin
                        if (cyc_r == TRIG_W'(1)) begin
                            state       <= LOAD;
                            cnt_reset_r <= 1'b0;
                            cnt_write_r <= 1'b1;
                        end else begin
                            cyc_r <= cyc_r + TRIG_W'(1);
                        end
                    end
                    LOAD: begin
                        state       <= ARM;
                        cnt_write_r <= 1'b0;
                        cnt_trig_r  <= 1'b1;
                        cyc_r       <= TRIG_W'(1);
                    end
                    ARM: begin
                        if (cyc_r == tl_r) begin
                            state      <= RUN;
                            cnt_trig_r <= 1'b0;
                        end else begin
                            cyc_r <= cyc_r + TRIG_W'(1);
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    FIN: begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        cnt_tao_r <= TAO_IDLE;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase

                // frame capture sits after the case so completion overrides ARM/RUN sequencing
                if (capture) begin
                    frames_done <= frames_inc;
                    if (!bus.fifo_full) begin
                        fifo_wr_r   <= 1'b1;
                        fifo_data_r <= bus.cnt_stream;
                    end else begin
                        overflow <= 1'b1;
                    end
                    if (last_frame) begin
                        state      <= FIN;
                        done       <= 1'b1;
                        cnt_trig_r <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pls_acq_seq.sv
// Scoreboard bench for pls_acq_seq: expected FIFO words are queued as
// frames are driven and compared when the sequencer writes them.
module tb_pls_acq_seq;

    localparam int unsigned NF_W   = 16;
    localparam int unsigned TRIG_W = 8;

    logic              CLK = 1'b0;
    logic              RESET = 1'b1;
    logic              cfg_start = 1'b0;
    logic              cfg_abort = 1'b0;
    logic [31:0]       cfg_tao = '0;
    logic [NF_W-1:0]   cfg_nframes = '0;
    logic [TRIG_W-1:0] cfg_trig_len = '0;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              overflow;
    logic [NF_W-1:0]   frames_done;

    pls_acq_seq_if bus();

    pls_acq_seq #(
        .NF_W   (NF_W),
        .TRIG_W (TRIG_W)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .cfg_start    (cfg_start),
        .cfg_abort    (cfg_abort),
        .cfg_tao      (cfg_tao),
        .cfg_nframes  (cfg_nframes),
        .cfg_trig_len (cfg_trig_len),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .overflow     (overflow),
        .frames_done  (frames_done)
    );

    always #5 CLK = ~CLK;

    int          checks = 0;
    int          failures = 0;
    int          n_wr = 0;
    int          n_done = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // FIFO write monitor: every write must match the oldest queued word
    always @(negedge CLK) begin
        if (!RESET) begin
            if (bus.fifo_wr === 1'b1) begin
                n_wr++;
                check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) check("fifo_data", bus.fifo_data, exp_q.pop_front());
            end
            if (done === 1'b1) n_done++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic gap(input int unsigned n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Issue a start and verify the CLR/LOAD/ARM sequence; returns in the second RUN cycle
    task automatic start_run(input logic [31:0] tao, input logic [NF_W-1:0] nf,
                             input logic [TRIG_W-1:0] tl);
        logic [31:0] tao_e;
        int unsigned tl_e;
        tao_e = (tao == 0) ? 32'd1 : tao;
        tl_e  = (tl == 0) ? 1 : int'(tl);
        cfg_tao      = tao;
        cfg_nframes  = nf;
        cfg_trig_len = tl;
        cfg_start    = 1'b1;
        @(posedge CLK);
        #1;
        cfg_start = 1'b0;
        for (int unsigned c = 1; c <= 4 + tl_e; c++) begin
            @(negedge CLK);
            check("seq_busy", busy, 1);
            check("seq_cnt_reset", bus.cnt_reset, (c <= 2) ? 1 : 0);
            check("seq_cnt_write", bus.cnt_write, (c == 3) ? 1 : 0);
            check("seq_cnt_trig", bus.cnt_trig, (c >= 4 && c <= 3 + tl_e) ? 1 : 0);
            if (c == 1) begin
                check("seq_cnt_tao", bus.cnt_tao, tao_e);
                check("seq_frames_clr", frames_done, 0);
                check("seq_overflow_clr", overflow, 0);
                check("seq_aborted_clr", aborted, 0);
            end
            if (c < 4 + tl_e) begin
                @(posedge CLK);
                #1;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    // One cnt_rdy cycle; returns at the negedge of the following cycle
    task automatic frame(input logic [63:0] d, input bit full, input bit abrt,
                         input int unsigned exp_fd);
        bus.cnt_rdy    = 1'b1;
        bus.cnt_stream = d;
        bus.fifo_full  = full;
        cfg_abort      = abrt;
        if (!full && !abrt) exp_q.push_back(d);
        @(posedge CLK);
        #1;
        bus.cnt_rdy    = 1'b0;
        bus.fifo_full  = 1'b0;
        cfg_abort      = 1'b0;
        bus.cnt_stream = {$urandom, $urandom};
        @(negedge CLK);
        check("frames_done", frames_done, exp_fd);
    endtask

    task automatic end_of_run(input string tag, input int exp_wr, input int exp_done);
        @(posedge CLK);
        #1;
        check({tag, "_n_wr"}, n_wr, exp_wr);
        check({tag, "_n_done"}, n_done, exp_done);
        check({tag, "_q_empty"}, exp_q.size(), 0);
    endtask

    task automatic reset_values(input string tag);
        check({tag, "_cnt_reset"}, bus.cnt_reset, 1);
        check({tag, "_cnt_write"}, bus.cnt_write, 0);
        check({tag, "_cnt_trig"}, bus.cnt_trig, 0);
        check({tag, "_cnt_tao"}, bus.cnt_tao, 32'h0000FFFF);
        check({tag, "_fifo_wr"}, bus.fifo_wr, 0);
        check({tag, "_fifo_data"}, bus.fifo_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_frames_done"}, frames_done, 0);
    endtask

    initial begin
        bus.cnt_rdy    = 1'b0;
        bus.cnt_stream = '0;
        bus.fifo_full  = 1'b0;

        // reset state
        gap(2);
        @(negedge CLK);
        reset_values("rst");
        RESET = 1'b0;
        gap(3);
        @(negedge CLK);
        check("rst_cnt_reset_low", bus.cnt_reset, 0);

        // nominal run: tao=4, 3 frames, trigger 2 cycles
        n_wr = 0; n_done = 0;
        start_run(32'd4, 16'd3, 8'd2);
        frame(64'h1111_2222_3333_4444, 0, 0, 1);
        gap(3);
        frame(64'hDEAD_BEEF_0000_0001, 0, 0, 2);
        gap(3);
        frame(64'h8000_0000_FFFF_0003, 0, 0, 3);
        check("nom_done", done, 1);
        check("nom_busy_fin", busy, 1);
        gap(1);
        @(negedge CLK);
        check("nom_busy_idle", busy, 0);
        check("nom_done_low", done, 0);
        check("nom_frames", frames_done, 3);
        end_of_run("nom", 3, 1);

        // abort while idle does nothing
        cfg_abort = 1'b1;
        gap(1);
        cfg_abort = 1'b0;
        @(negedge CLK);
        check("idle_abort_aborted", aborted, 0);
        check("idle_abort_busy", busy, 0);

        // clamping: tao=0 and trig_len=0 behave as 1
        n_wr = 0; n_done = 0;
        start_run(32'd0, 16'd1, 8'd0);
        frame(64'h0123_4567_89AB_CDEF, 0, 0, 1);
        check("clamp_done", done, 1);
        end_of_run("clamp", 1, 1);

        // backpressure on the second frame
        n_wr = 0; n_done = 0;
        start_run(32'd2, 16'd4, 8'd3);
        frame(64'hA0A0_0000_0000_0001, 0, 0, 1);
        gap(1);
        frame(64'hA0A0_0000_0000_0002, 1, 0, 2);
        check("bp_overflow", overflow, 1);
        check("bp_no_wr", bus.fifo_wr, 0);
        gap(1);
        frame(64'hA0A0_0000_0000_0003, 0, 0, 3);
        gap(1);
        frame(64'hA0A0_0000_0000_0004, 0, 0, 4);
        check("bp_done", done, 1);
        check("bp_overflow_sticky", overflow, 1);
        end_of_run("bp", 3, 1);

        // abort mid-run on a frame cycle, free-running run
        n_wr = 0; n_done = 0;
        start_run(32'd2, 16'd0, 8'd1);
        for (int unsigned i = 1; i <= 5; i++) begin
            frame({$urandom, $urandom}, 0, 0, i);
            gap(1);
        end
        frame(64'hBAD0_BAD0_BAD0_BAD0, 0, 1, 5);
        check("abt_busy", busy, 0);
        check("abt_aborted", aborted, 1);
        check("abt_done", done, 0);
        check("abt_fifo_wr", bus.fifo_wr, 0);
        check("abt_cnt_trig", bus.cnt_trig, 0);
        end_of_run("abt", 5, 0);

        // streaming: tao=1, cnt_rdy held high for 8 cycles
        n_wr = 0; n_done = 0;
        start_run(32'd1, 16'd8, 8'd1);
        for (int unsigned i = 0; i < 8; i++) begin
            logic [63:0] w;
            w = {$urandom, $urandom};
            bus.cnt_rdy    = 1'b1;
            bus.cnt_stream = w;
            exp_q.push_back(w);
            @(posedge CLK);
            #1;
            @(negedge CLK);
            check("stream_wr", bus.fifo_wr, 1);
            check("stream_frames", frames_done, i + 1);
        end
        bus.cnt_rdy = 1'b0;
        check("stream_done", done, 1);
        gap(1);
        @(negedge CLK);
        check("stream_busy_idle", busy, 0);
        end_of_run("stream", 8, 1);

        // reset asserted while the trigger is high
        cfg_tao = 32'd5; cfg_nframes = 16'd2; cfg_trig_len = 8'd4;
        cfg_start = 1'b1;
        gap(1);
        cfg_start = 1'b0;
        gap(3);
        @(negedge CLK);
        check("rarm_trig", bus.cnt_trig, 1);
        RESET = 1'b1;
        exp_q.delete();
        gap(1);
        RESET = 1'b0;
        @(negedge CLK);
        reset_values("rarm");
        gap(2);
        @(negedge CLK);
        check("rarm_idle_busy", busy, 0);

        // start during RUN is ignored and config stays latched
        n_wr = 0; n_done = 0;
        start_run(32'd3, 16'd2, 8'd1);
        frame(64'h5555_AAAA_5555_AAAA, 0, 0, 1);
        gap(1);
        cfg_tao = 32'd99; cfg_nframes = 16'd7; cfg_trig_len = 8'd9;
        cfg_start = 1'b1;
        gap(1);
        cfg_start = 1'b0;
        @(negedge CLK);
        check("ign_busy", busy, 1);
        check("ign_cnt_reset", bus.cnt_reset, 0);
        check("ign_cnt_trig", bus.cnt_trig, 0);
        check("ign_cnt_tao", bus.cnt_tao, 3);
        check("ign_frames", frames_done, 1);
        gap(1);
        frame(64'h0F0F_0F0F_F0F0_F0F0, 0, 0, 2);
        check("ign_done", done, 1);
        end_of_run("ign", 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pls_acq_seq.md
# pls_acq_seq

Acquisition sequencer for the photon pulse counter. It takes a host run command (frame period, frame count, trigger width) and drives the counter's reset, configuration-write and trigger inputs in order. It then captures each 64-bit count word the counter emits into the downstream FIFO, and reports busy, done, overflow and progress back to the HPS register map.

## Interface
Parameters:
- NF_W, 16: width of the frame count and frame progress counter.
- TRIG_W, 8: width of the trigger pulse length field.

Ports:
- CLK  in  1  system clock; the only clock.
- RESET  in  1  synchronous, active-high reset.
- cfg_start  in  1  single-cycle run request; sampled only in IDLE.
- cfg_abort  in  1  single-cycle abort; honoured in any non-IDLE state.
- cfg_tao  in  32  frame period in CLK cycles; latched at start.
- cfg_nframes  in  NF_W  number of frames to capture; 0 means run until abort.
- cfg_trig_len  in  TRIG_W  trigger high time in cycles; 0 is treated as 1.
- cnt_reset  out  1  drives the counter's RESET.
- cnt_write  out  1  drives the counter's write.
- cnt_tao  out  32  drives the counter's Tao_Q.
- cnt_trig  out  1  drives the counter's TRIIN.
- cnt_rdy  in  1  counter's RDY.
- cnt_stream  in  64  counter's Cnt_Stream.
- fifo_data  out  64  FIFO write data.
- fifo_wr  out  1  FIFO write strobe.
- fifo_full  in  1  FIFO full flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when a run completes normally.
- aborted  out  1  sticky; set by an abort; cleared at the next accepted start.
- overflow  out  1  sticky; set when a frame is dropped; cleared at the next accepted start.
- frames_done  out  NF_W  frames completed in the current run, including dropped frames.

## Operation
- States: IDLE, CLR, LOAD, ARM, RUN, FIN.
- IDLE:
  - cfg_start=1 latches tao_r, nf_r and tl_r, clears frames_done, aborted and overflow, then moves to CLR.
  - tao_r = max(cfg_tao, 1); tl_r = max(cfg_trig_len, 1).
- CLR: cnt_reset=1 for exactly 2 cycles, then LOAD.
- LOAD: cnt_write=1 for exactly 1 cycle, then ARM. cnt_tao = tao_r, driven from the first CLR cycle until return to IDLE.
- ARM: cnt_trig=1 for exactly tl_r cycles, then RUN.
- RUN:
  - Every cycle with cnt_rdy=1 counts as one frame; frames_done increments (wraps at 2^NF_W).
  - If fifo_full=0: the next cycle has fifo_wr=1 and fifo_data = the cnt_stream value sampled in the cnt_rdy cycle.
  - If fifo_full=1: no write and overflow is set.
  - When nf_r≠0 and the increment makes frames_done equal nf_r, go to FIN.
  - cnt_rdy is also captured during ARM under the same rules, since the counter emits its boundary word while triggered.
- FIN: done=1 for 1 cycle, then IDLE. A fifo_wr pending from the last frame still issues in the FIN cycle.
- Abort (cfg_abort=1 in CLR/LOAD/ARM/RUN/FIN):
  - Next state is IDLE.
  - aborted=1; done is not pulsed.
  - cnt_trig and cnt_write drop the next cycle.
  - A pending fifo_wr for a frame captured in the abort cycle is discarded.
  - Abort in IDLE: no effect.
- cfg_start outside IDLE is ignored. cfg_start and cfg_abort together in IDLE: start wins.
- cfg_* changes after start have no effect on the run in progress.

## Timing
- Reset values:
  - State IDLE.
  - cnt_reset=1 while RESET=1 and 0 after.
  - cnt_write, cnt_trig, fifo_wr, busy, done, aborted, overflow = 0.
  - fifo_data, frames_done = 0.
  - cnt_tao = 32'h0000FFFF.
- All outputs are registered.
- Start latency: start in cycle N, then busy=1 and cnt_reset=1 in N+1 and N+2, cnt_write=1 in N+3, cnt_trig=1 in N+4 … N+3+tl_r.
- Capture latency: cnt_rdy in cycle M gives fifo_wr in M+1; frames_done updates in M+1.
- Back-to-back cnt_rdy (tao_r=1) gives continuous fifo_wr, one word per cycle.
- Completion: the final cnt_rdy in M puts FIN in M+1 (done=1, fifo_wr=1), IDLE and busy=0 in M+2.
- RESET mid-run: the next cycle has all outputs at reset values, with no write and no done.

## Test plan
- Nominal run: tao=4, nframes=3, trig_len=2, fifo never full. Expect cnt_reset 2 cycles, cnt_write 1, cnt_trig 2, exactly 3 fifo_wr with data equal to the sampled cnt_stream, done pulse, frames_done=3, busy low 2 cycles after the 3rd cnt_rdy.
- Clamping: cfg_tao=0 and trig_len=0 give cnt_tao=1 and cnt_trig high exactly 1 cycle.
- Backpressure: nframes=4, fifo_full=1 during the 2nd cnt_rdy. Expect 3 fifo_wr, overflow=1, frames_done=4, done pulse.
- Abort mid-RUN: nframes=0, abort after 5 frames. Expect IDLE next cycle, aborted=1, no done, frames_done=5, no write for a cnt_rdy coincident with abort.
- Streaming: tao=1 with cnt_rdy held high 8 cycles, nframes=8. Expect 8 consecutive fifo_wr, then done.
- Reset and ignored start: RESET asserted during ARM gives all outputs at reset values next cycle; cfg_start during RUN does not change state or latched config.
